wb_master_seq: RTL and testbench



---
 rtl/wb_master_seq_pkg.sv | 19 +
 rtl/wb_master_seq_if.sv | 42 ++++
 rtl/wb_master_seq_cmd_fifo.sv | 56 +++++
 rtl/wb_master_seq.sv | 142 ++++++++++++++
 tb/tb_wb_master_seq.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_master_seq_pkg.sv
// Shared types and widths for the Wishbone command sequencer slice.
package wb_pkg;

    localparam int unsigned WB_ADDR_W = 8;
    localparam int unsigned WB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } wb_mst_state_e;

    typedef struct packed {
        logic                 we;
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] wdata;
    } wb_cmd_t;

endpackage

// File: rtl/wb_master_seq_if.sv
// Command, response and Wishbone bus signals of the sequencer, with master/slave views.
interface wb_master_seq_if;
    import wb_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_we;
    logic [WB_ADDR_W-1:0] cmd_addr;
    logic [WB_DATA_W-1:0] cmd_wdata;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_we;
    logic [WB_DATA_W-1:0] rsp_rdata;
    logic                 rsp_err;

    logic                 wb_strb;
    logic                 wb_we;
    logic [WB_ADDR_W-1:0] wb_addr;
    logic [WB_DATA_W-1:0] wb_wdata;
    logic                 wb_ack;
    logic [WB_DATA_W-1:0] wb_rdata;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_we, rsp_rdata, rsp_err,
        input  rsp_ready,
        output wb_strb, wb_we, wb_addr, wb_wdata,
        input  wb_ack, wb_rdata
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_we, rsp_rdata, rsp_err,
        output rsp_ready,
        input  wb_strb, wb_we, wb_addr, wb_wdata,
        output wb_ack, wb_rdata
    );

endinterface

// File: rtl/wb_master_seq_cmd_fifo.sv
// Command FIFO for the sequencer: power-of-2 depth, wrapping pointers, occupancy count.
module wb_cmd_fifo
    import wb_pkg::*;
#(
    parameter int unsigned CMD_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  wb_cmd_t                      push_data_i,
    input  logic                         pop_i,
    output wb_cmd_t                      pop_data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(CMD_DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(CMD_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(CMD_DEPTH);

    if ((CMD_DEPTH < 2) || ((CMD_DEPTH & (CMD_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("wb_cmd_fifo: CMD_DEPTH must be a power of 2 and at least 2");
    end

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    wb_cmd_t          mem_q [CMD_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; the cleared count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = (count_q == FULL_CNT);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/wb_master_seq.sv
// Wishbone command sequencer: queues commands, runs one bus transaction at a time, returns in order.
// Optional REQ-phase timeout abort is enabled by defining WB_TIMEOUT_EN.
module wb_master_seq
    import wb_pkg::*;
#(
    parameter int unsigned CMD_DEPTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_master_seq_if.master   bus,
    output logic              busy
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("wb_master_seq: TIMEOUT_CYCLES must be at least 1");
    end

    wb_mst_state_e          state_q;
    logic                   strb_q;
    logic                   we_q;
    logic [WB_ADDR_W-1:0]   addr_q;
    logic [WB_DATA_W-1:0]   wdata_q;
    logic                   rsp_valid_q;
    logic                   rsp_we_q;
    logic [WB_DATA_W-1:0]   rsp_rdata_q;

    wb_cmd_t                push_cmd;
    wb_cmd_t                head_cmd;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(CMD_DEPTH):0] fifo_count;

    assign push_cmd  = {bus.cmd_we, bus.cmd_addr, bus.cmd_wdata};
    assign fifo_push = bus.cmd_valid && !fifo_full;
    assign fifo_pop  = (state_q == IDLE) && !fifo_empty;

    wb_cmd_fifo #(
        .CMD_DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i (push_cmd),
        .pop_i       (fifo_pop),
        .pop_data_o  (head_cmd),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

`ifdef WB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic             rsp_err_q;
    logic [TMO_W-1:0] tmo_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            strb_q      <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef WB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
            tmo_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        strb_q  <= 1'b1;
                        we_q    <= head_cmd.we;
                        addr_q  <= head_cmd.addr;
                        wdata_q <= head_cmd.wdata;
`ifdef WB_TIMEOUT_EN
                        tmo_q   <= '0;
`endif
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (bus.wb_ack) begin
                        strb_q      <= 1'b0;
                        rsp_rdata_q <= we_q ? '0 : bus.wb_rdata;
                        rsp_we_q    <= we_q;
                        rsp_valid_q <= 1'b1;
`ifdef WB_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
`endif
                        state_q     <= RSP;
                    end
`ifdef WB_TIMEOUT_EN
                    // Ack is tested first so an ack on the timeout edge still completes normally.
                    else if (tmo_q == TMO_LAST) begin
                        strb_q      <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_we_q    <= we_q;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RSP;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                RSP: begin
                    if (rsp_valid_q && bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = !fifo_full;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_we    = rsp_we_q;
    assign bus.rsp_rdata = rsp_rdata_q;
`ifdef WB_TIMEOUT_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif
    assign bus.wb_strb   = strb_q;
    assign bus.wb_we     = we_q;
    assign bus.wb_addr   = addr_q;
    assign bus.wb_wdata  = wdata_q;

    assign busy = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_wb_master_seq.sv
// Bench for wb_master_seq: random commands against a memory-level reference and a Wishbone slave model.
module tb_wb_master_seq;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    wb_master_seq_if bus ();

    wb_master_seq #(
        .CMD_DEPTH      (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: memory contents in command order, expected bus commands and responses.
    logic [7:0]  ref_mem [256];
    logic [16:0] bus_q [$];
    logic [9:0]  rsp_q [$];
    logic        slv_en, bp_hold, tmo_mode;

    task automatic ref_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h11;
        bus_q.delete();
        rsp_q.delete();
    endtask

    task automatic model_cmd(input logic we, input logic [7:0] a, input logic [7:0] d);
        bus_q.push_back({we, a, d});
        if (tmo_mode) begin
`ifdef WB_TIMEOUT_EN
            rsp_q.push_back({we, 8'h00, 1'b1});
`endif
        end else if (we) begin
            ref_mem[a] = d;
            rsp_q.push_back({1'b1, 8'h00, 1'b0});
        end else begin
            rsp_q.push_back({1'b0, ref_mem[a], 1'b0});
        end
    endtask

    // Slave: registered one-cycle ack after a random wait, memory initialised to 0x11 on reset.
    logic [7:0] slv_mem [256];
    int         slv_wait;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wb_ack   <= 1'b0;
            bus.wb_rdata <= 8'h00;
            slv_wait     <= 0;
            for (int i = 0; i < 256; i++) slv_mem[i] <= 8'h11;
        end else if (bus.wb_ack) begin
            bus.wb_ack <= 1'b0;
        end else if (slv_en && bus.wb_strb) begin
            if (slv_wait == 0) begin
                bus.wb_ack   <= 1'b1;
                bus.wb_rdata <= slv_mem[bus.wb_addr];
                if (bus.wb_we) slv_mem[bus.wb_addr] <= bus.wb_wdata;
                slv_wait <= int'($urandom_range(0, 2));
            end else begin
                slv_wait <= slv_wait - 1;
            end
        end
    end

    // Response consumer: random ready unless held off; compares each accepted response.
    always @(negedge clk) begin
        logic [9:0] e;
        if (!rst_n) begin
            bus.rsp_ready = 1'b0;
        end else begin
            bus.rsp_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", {31'b0, bus.rsp_valid}, 32'd0);
                end else begin
                    e = rsp_q.pop_front();
                    check("rsp", {22'b0, bus.rsp_we, bus.rsp_rdata, bus.rsp_err}, {22'b0, e});
                end
            end
        end
    end

    // Bus monitor: command order, field stability, idle gap, timeout length.
    logic        mon_prev = 1'b0;
    logic        mon_seen = 1'b0;
    logic        mon_stable;
    logic [16:0] mon_cur;
    int          mon_low = 0;
    int          mon_hi  = 0;

    always @(negedge clk) begin
        logic [16:0] now;
        now = {bus.wb_we, bus.wb_addr, bus.wb_wdata};
        if (!rst_n) begin
            mon_prev = 1'b0;
            mon_seen = 1'b0;
            mon_low  = 0;
        end else begin
            if (bus.wb_strb && !mon_prev) begin
                if (mon_seen) check("strb_gap_ge2", {31'b0, mon_low >= 2}, 32'd1);
                if (bus_q.size() == 0) check("bus_unexpected", {31'b0, bus.wb_strb}, 32'd0);
                else check("bus_cmd", {15'b0, now}, {15'b0, bus_q.pop_front()});
                mon_cur    = now;
                mon_stable = 1'b1;
                mon_hi     = 1;
            end else if (bus.wb_strb) begin
                if (now !== mon_cur) mon_stable = 1'b0;
                mon_hi++;
            end else if (mon_prev) begin
                check("bus_stable", {31'b0, mon_stable}, 32'd1);
`ifdef WB_TIMEOUT_EN
                if (tmo_mode) check("tmo_cycles", mon_hi, TMO);
`endif
                mon_seen = 1'b1;
                mon_low  = 1;
            end else if (mon_low < 1000) begin
                mon_low++;
            end
            mon_prev = bus.wb_strb;
        end
    end

    task automatic send(input logic we, input logic [7:0] a, input logic [7:0] d);
        int w = 0;
        while (!bus.cmd_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!bus.cmd_ready) begin
            check("cmd_ready_wait", {31'b0, bus.cmd_ready}, 32'd1);
        end else begin
            bus.cmd_valid = 1'b1;
            bus.cmd_we    = we;
            bus.cmd_addr  = a;
            bus.cmd_wdata = d;
            model_cmd(we, a, d);
            @(negedge clk);
            bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic drain(input int budget);
        int w = 0;
        while ((rsp_q.size() != 0 || busy || bus.rsp_valid) && w < budget) begin
            @(negedge clk);
            w++;
        end
        check("drain_rsp_left", rsp_q.size(), 32'd0);
        check("drain_bus_left", bus_q.size(), 32'd0);
        check("drain_busy", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int w;
        int hold_ok;
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = 8'h00;
        bus.cmd_wdata = 8'h00;
        slv_en   = 1'b1;
        bp_hold  = 1'b0;
        tmo_mode = 1'b0;
        ref_reset();

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_strb",      {31'b0, bus.wb_strb},   32'd0);
        check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
        check("rst_busy",      {31'b0, busy},          32'd0);
        check("rst_rsp_rdata", {24'b0, bus.rsp_rdata}, 32'd0);
        check("rst_rsp_err",   {31'b0, bus.rsp_err},   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write then read back, plus a read of untouched memory.
        send(1'b1, 8'h3C, 8'hA5);
        send(1'b0, 8'h3C, 8'h00);
        send(1'b0, 8'h80, 8'h00);
        drain(300);

        for (int i = 0; i < 6; i++) send(1'b1, 8'(8'h10 + i), 8'($urandom));
        drain(300);

        // Backpressure: one command stuck in RSP, four filling the FIFO.
        bp_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(i[0], 8'(8'h20 + i), 8'(8'hB0 + i));
            if (i == 3) check("cmd_ready_before_full", {31'b0, bus.cmd_ready}, 32'd1);
        end
        check("cmd_ready_full", {31'b0, bus.cmd_ready}, 32'd0);
        check("busy_bp", {31'b0, busy}, 32'd1);
        w = 0;
        while (!bus.rsp_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("bp_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
        hold_ok = 0;
        repeat (10) begin
            @(negedge clk);
            if (!bus.wb_strb && bus.rsp_valid && !bus.cmd_ready) hold_ok++;
        end
        check("bp_hold_cycles", hold_ok, 32'd10);
        bp_hold = 1'b0;
        drain(500);

        for (int i = 0; i < 60; i++) begin
            send(1'($urandom_range(0, 1)), 8'(8'h40 + $urandom_range(0, 3)), 8'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain(2000);

        // Slave silent: timeout abort (if built in), then a stalled REQ interrupted by reset.
        slv_en   = 1'b0;
        tmo_mode = 1'b1;
`ifdef WB_TIMEOUT_EN
        send(1'b0, 8'h55, 8'h00);
        drain(300);
`endif
        send(1'b0, 8'h56, 8'h00);
        w = 0;
        while (!bus.wb_strb && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("stall_strb_rise", {31'b0, bus.wb_strb}, 32'd1);
        send(1'b1, 8'h57, 8'h99);
        send(1'b0, 8'h58, 8'h00);
`ifndef WB_TIMEOUT_EN
        hold_ok = 0;
        repeat (120) begin
            @(negedge clk);
            if (bus.wb_strb && !bus.rsp_valid) hold_ok++;
        end
        check("req_persist", hold_ok, 32'd120);
`endif
        check("pre_rst_strb", {31'b0, bus.wb_strb}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_strb",      {31'b0, bus.wb_strb},   32'd0);
        check("async_rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("async_rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
        check("async_rst_busy",      {31'b0, busy},          32'd0);
        ref_reset();
        tmo_mode = 1'b0;
        slv_en   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        send(1'b0, 8'h80, 8'h00);
        send(1'b0, 8'h57, 8'h00);
        send(1'b1, 8'h3C, 8'h5A);
        send(1'b0, 8'h3C, 8'h00);
        drain(300);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
